// File: rtl/pkg_buffer_controller_if.sv
// Signal bundle between the packet buffer controller and its requesters,
// free/data table managers and page RAM.
interface pkg_buffer_controller_if #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_PAGE_NUM_LOG = 4
);
    logic                         wr_req;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic                         wr_ack;
    logic                         rd_req;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic                         rd_valid;
    logic                         free_table_read_req;
    logic [ADDR_PAGE_NUM_LOG-1:0] free_table_read_addr;
    logic                         free_table_empty;
    logic                         free_table_write_req;
    logic [ADDR_PAGE_NUM_LOG-1:0] free_table_write_addr;
    logic                         data_table_read_req;
    logic [ADDR_PAGE_NUM_LOG-1:0] data_table_read_addr;
    logic                         data_table_empty;
    logic                         data_table_write_req;
    logic [ADDR_PAGE_NUM_LOG-1:0] data_table_write_addr;
    logic [ADDR_PAGE_NUM_LOG-1:0] ram_addr;
    logic                         ram_wr_en;
    logic [DATA_WIDTH-1:0]        ram_wr_data;
    logic [DATA_WIDTH-1:0]        ram_rd_data;
    logic [ADDR_PAGE_NUM_LOG:0]   pkt_count;
    logic                         busy;

    modport slave (
        input  wr_req, wr_data, rd_req,
        input  free_table_read_addr, free_table_empty,
        input  data_table_read_addr, data_table_empty, ram_rd_data,
        output wr_ack, rd_data, rd_valid,
        output free_table_read_req, free_table_write_req, free_table_write_addr,
        output data_table_read_req, data_table_write_req, data_table_write_addr,
        output ram_addr, ram_wr_en, ram_wr_data, pkt_count, busy
    );

    modport master (
        output wr_req, wr_data, rd_req,
        output free_table_read_addr, free_table_empty,
        output data_table_read_addr, data_table_empty, ram_rd_data,
        input  wr_ack, rd_data, rd_valid,
        input  free_table_read_req, free_table_write_req, free_table_write_addr,
        input  data_table_read_req, data_table_write_req, data_table_write_addr,
        input  ram_addr, ram_wr_en, ram_wr_data, pkt_count, busy
    );
endinterface

// File: rtl/pkg_buffer_controller.sv
// Linked-list packet buffer sequencer: round-robin between one-word writes
// (alloc, store, link) and reads (pop, fetch, free) over shared tables and RAM.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | arbitrate eligible write/read requests
// WR_ALLOC  | pop free-list head, latch page
// WR_DATA   | write word into page RAM, ack requester
// WR_LINK   | append page to data list
// RD_POP    | pop oldest data page, latch page
// RD_ADDR   | present page address to RAM
// RD_CAPT   | RAM data valid, return word to requester
// RD_FREE   | push page back onto free list
// WAIT      | table settle time (TABLE_LAT cycles)
module pkg_buffer_controller #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_PAGE_NUM_LOG = 4,
    parameter int TABLE_LAT         = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pkg_buffer_controller_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_WR_ALLOC, S_WR_DATA, S_WR_LINK,
        S_RD_POP, S_RD_ADDR, S_RD_CAPT, S_RD_FREE, S_WAIT
    } state_t;

    localparam logic [3:0]                 WAIT_LOAD = 4'(TABLE_LAT - 1);
    localparam logic [ADDR_PAGE_NUM_LOG:0] CNT_ONE   = (ADDR_PAGE_NUM_LOG+1)'(1);

    state_t                       state, state_nxt;
    logic [ADDR_PAGE_NUM_LOG-1:0] page;
    logic [3:0]                   wait_cnt;
    logic                         prefer_rd;
    logic [ADDR_PAGE_NUM_LOG:0]   pkt_count_q;
    logic [DATA_WIDTH-1:0]        rd_data_q;
    logic                         wr_elig, rd_elig, grant_wr, grant_rd;

    assign wr_elig  = bus.wr_req & ~bus.free_table_empty;
    assign rd_elig  = bus.rd_req & ~bus.data_table_empty;
    assign grant_wr = wr_elig & (~rd_elig | ~prefer_rd);
    assign grant_rd = rd_elig & ~grant_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            page        <= '0;
            wait_cnt    <= '0;
            prefer_rd   <= 1'b0;
            pkt_count_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                if (grant_wr)      prefer_rd <= 1'b1;
                else if (grant_rd) prefer_rd <= 1'b0;
            end
            if (state == S_WR_ALLOC) page <= bus.free_table_read_addr;
            if (state == S_RD_POP)   page <= bus.data_table_read_addr;
            if (state_nxt == S_WAIT && state != S_WAIT)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == S_WR_LINK) pkt_count_q <= pkt_count_q + CNT_ONE;
            if (state == S_RD_POP)  pkt_count_q <= pkt_count_q - CNT_ONE;
            if (state == S_RD_CAPT) rd_data_q   <= bus.ram_rd_data;
        end
    end

    always_comb begin
        state_nxt                 = state;
        bus.wr_ack                = 1'b0;
        bus.rd_valid              = 1'b0;
        bus.free_table_read_req   = 1'b0;
        bus.free_table_write_req  = 1'b0;
        bus.free_table_write_addr = '0;
        bus.data_table_read_req   = 1'b0;
        bus.data_table_write_req  = 1'b0;
        bus.data_table_write_addr = '0;
        bus.ram_addr              = '0;
        bus.ram_wr_en             = 1'b0;
        bus.ram_wr_data           = '0;
        case (state)
            S_IDLE: begin
                if (grant_wr)      state_nxt = S_WR_ALLOC;
                else if (grant_rd) state_nxt = S_RD_POP;
            end
            S_WR_ALLOC: begin
                bus.free_table_read_req = 1'b1;
                state_nxt               = S_WR_DATA;
            end
            S_WR_DATA: begin
                bus.ram_addr    = page;
                bus.ram_wr_en   = 1'b1;
                bus.ram_wr_data = bus.wr_data;
                bus.wr_ack      = 1'b1;
                state_nxt       = S_WR_LINK;
            end
            S_WR_LINK: begin
                bus.data_table_write_req  = 1'b1;
                bus.data_table_write_addr = page;
                state_nxt                 = S_WAIT;
            end
            S_RD_POP: begin
                bus.data_table_read_req = 1'b1;
                state_nxt               = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                bus.ram_addr = page;
                state_nxt    = S_RD_CAPT;
            end
            S_RD_CAPT: begin
                bus.rd_valid = 1'b1;
                state_nxt    = S_RD_FREE;
            end
            S_RD_FREE: begin
                bus.free_table_write_req  = 1'b1;
                bus.free_table_write_addr = page;
                state_nxt                 = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM word is forwarded in the capture cycle and held afterwards
    assign bus.rd_data   = (state == S_RD_CAPT) ? bus.ram_rd_data : rd_data_q;
    assign bus.pkt_count = pkt_count_q;
    assign bus.busy      = (state != S_IDLE);
endmodule
